// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache with 4-word lines, refilled
// from instruction memory by an in-order burst; stalls the PC on a miss.
module inst_cache #(
    parameter int bit_size   = 18,
    parameter int data_size  = 32,
    parameter int index_bits = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [bit_size-1:0]  addr,
    input  logic                 flush,
    output logic [data_size-1:0] inst,
    output logic                 inst_valid,
    output logic                 stall,
    output logic                 mem_read,
    output logic [bit_size-1:0]  mem_addr,
    input  logic                 mem_rvalid,
    input  logic [data_size-1:0] mem_rdata,
    output logic [15:0]          miss_count
);
    localparam int lines    = 1 << index_bits;
    localparam int tag_bits = bit_size - 4 - index_bits;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                  state, state_n;
    logic [lines-1:0]        valid;
    logic [tag_bits-1:0]     tags [lines];
    logic [data_size-1:0]    data [lines*4];
    logic [bit_size-5:0]     line_q;
    logic [1:0]              cnt;
    logic [index_bits-1:0]   idx, fill_idx;
    logic [tag_bits-1:0]     tag;
    logic [1:0]              wrd;
    logic                    idle, hit, miss, start, fill_done;
    logic                    unused;

    assign unused    = ^addr[1:0];
    assign wrd       = addr[3:2];
    assign idx       = addr[3+index_bits:4];
    assign tag       = addr[bit_size-1:4+index_bits];
    assign fill_idx  = line_q[index_bits-1:0];
    assign idle      = state == IDLE;
    assign hit       = req && valid[idx] && tags[idx] == tag;
    assign miss      = idle && req && !hit;
    // flush wins over a same-cycle miss so no refill is started into a cleared cache
    assign start     = miss && !flush;
    assign fill_done = !idle && mem_rvalid && cnt == 2'd3;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = start ? REFILL : fill_done ? IDLE : state;
    end

    always_comb begin
        inst_valid = idle && hit;
        inst       = inst_valid ? data[{idx, wrd}] : '0;
        stall      = idle ? req && !hit : 1'b1;
        mem_read   = !idle;
        mem_addr   = idle ? '0 : {line_q, 4'b0000};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            cnt        <= '0;
            miss_count <= '0;
        end else if (idle) begin
            if (flush) valid <= '0;
            else if (miss) begin
                cnt <= '0;
                if (miss_count != 16'hffff) miss_count <= miss_count + 16'd1;
            end
        end else if (mem_rvalid) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) line_q <= addr[bit_size-1:4];
        if (!idle && mem_rvalid) data[{fill_idx, cnt}] <= mem_rdata;
        if (fill_done) tags[fill_idx] <= line_q[bit_size-5:index_bits];
    end
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed plus randomized fetches against a model that tracks
// resident lines by line address and holds the words each refill delivered.
module tb_inst_cache;
    logic        clk = 0, rst = 1, req = 0, flush = 0, mem_rvalid = 0;
    logic [17:0] addr = '0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] inst;
    logic        inst_valid, stall, mem_read;
    logic [17:0] mem_addr;
    logic [15:0] miss_count;

    int vectors = 0, miscompares = 0, mc = 0, n;
    logic [127:0] res [int];

    inst_cache dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
        .inst(inst), .inst_valid(inst_valid), .stall(stall),
        .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s obs=%h exp=%h", t, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic install(input int line, input logic [127:0] w);
        int vic[$];
        foreach (res[k]) if ((k & 15) == (line & 15)) vic.push_back(k);
        foreach (vic[i]) res.delete(vic[i]);
        res[line] = w;
    endtask

    task automatic fetch(input logic [17:0] a, input logic [127:0] w, input logic [7:0] pat,
                         input int plen, input bit hold_flush, output int stalls);
        int line, wi, beat, it;
        line = int'(a >> 4);
        wi = int'(a[3:2]);
        beat = 0;
        it = 0;
        stalls = 0;
        req = 1;
        addr = a;
        @(negedge clk);
        if (res.exists(line)) begin
            chk("hit_inst", inst, res[line][32*wi +: 32]);
            chk("hit_valid", 32'(inst_valid), 1);
            chk("hit_stall", 32'(stall), 0);
            chk("hit_memread", 32'(mem_read), 0);
            chk("hit_misscount", 32'(miss_count), 32'(mc));
            step();
            return;
        end
        chk("miss_stall", 32'(stall), 1);
        chk("miss_valid", 32'(inst_valid), 0);
        chk("miss_inst", inst, 0);
        stalls = 1;
        mc++;
        step();
        while (beat < 4 && it < 64) begin
            mem_rvalid = plen > 0 ? pat[it % plen] : 1'($urandom_range(0, 1));
            mem_rdata = w[32*beat +: 32];
            addr = 18'($urandom);
            req = 1'($urandom_range(0, 1));
            if (hold_flush) flush = 1;
            @(negedge clk);
            chk("refill_memread", 32'(mem_read), 1);
            chk("refill_memaddr", 32'(mem_addr), 32'(line) << 4);
            chk("refill_stall", 32'(stall), 1);
            stalls++;
            it++;
            step();
            if (mem_rvalid) beat++;
        end
        if (beat < 4) chk("refill_timeout", 32'(beat), 4);
        mem_rvalid = 0;
        mem_rdata = $urandom;
        req = 1;
        addr = a;
        install(line, w);
        @(negedge clk);
        chk("post_inst", inst, w[32*wi +: 32]);
        chk("post_valid", 32'(inst_valid), 1);
        chk("post_stall", 32'(stall), 0);
        chk("post_memread", 32'(mem_read), 0);
        chk("post_misscount", 32'(miss_count), 32'(mc));
        step();
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        step();
        step();
        rst = 0;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_inst", inst, 0);
        chk("rst_memread", 32'(mem_read), 0);
        chk("rst_memaddr", 32'(mem_addr), 0);
        chk("rst_misscount", 32'(miss_count), 0);
        step();

        fetch(18'h00004, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'h01, 1, 0, n);
        chk("fill_stall_cycles", 32'(n), 5);
        fetch(18'h00000, '0, 8'h01, 1, 0, n);
        fetch(18'h00008, '0, 8'h01, 1, 0, n);
        fetch(18'h0000C, '0, 8'h01, 1, 0, n);
        fetch(18'h00100, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 8'h01, 1, 0, n);
        fetch(18'h00004, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'h01, 1, 0, n);
        chk("conflict_misscount", 32'(miss_count), 3);

        fetch(18'h00214, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 8'h59, 7, 0, n);
        chk("gap_stall_cycles", 32'(n), 8);
        fetch(18'h00210, '0, 8'h01, 1, 0, n);
        fetch(18'h0021C, '0, 8'h01, 1, 0, n);

        req = 0;
        @(negedge clk);
        chk("idle_stall", 32'(stall), 0);
        chk("idle_valid", 32'(inst_valid), 0);
        chk("idle_inst", inst, 0);
        step();

        // reset in the middle of a refill, on the third beat
        req = 1;
        addr = 18'h00024;
        step();
        mem_rvalid = 1;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        mem_rvalid = 0;
        req = 0;
        res.delete();
        mc = 0;
        @(negedge clk);
        chk("midrst_memread", 32'(mem_read), 0);
        chk("midrst_misscount", 32'(miss_count), 0);
        chk("midrst_stall", 32'(stall), 0);
        step();
        fetch(18'h00024, rnd_line(), 8'h01, 1, 0, n);
        chk("midrst_refetch_mc", 32'(miss_count), 1);
        fetch(18'h00004, rnd_line(), 8'h01, 1, 0, n);

        req = 0;
        flush = 1;
        step();
        flush = 0;
        res.delete();
        fetch(18'h00024, rnd_line(), 8'h01, 1, 0, n);
        chk("flush_refill_stalls", 32'(n), 5);

        // flush with a same-cycle miss: no refill, count unchanged
        req = 1;
        addr = 18'h3F000;
        flush = 1;
        step();
        flush = 0;
        req = 0;
        res.delete();
        @(negedge clk);
        chk("flushmiss_memread", 32'(mem_read), 0);
        chk("flushmiss_misscount", 32'(miss_count), 32'(mc));
        step();

        fetch(18'h00038, rnd_line(), 8'h00, 0, 1, n);
        flush = 0;
        res.delete();
        fetch(18'h00038, rnd_line(), 8'h00, 0, 0, n);
        chk("heldflush_refill_stalls", 32'(n) >= 5 ? 1 : 0, 1);

        for (int i = 0; i < 60; i++) begin
            logic [17:0] a;
            a = {8'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 2'b00};
            fetch(a, rnd_line(), 8'h00, 0, 0, n);
            if ($urandom_range(0, 4) == 0) begin
                req = 0;
                @(negedge clk);
                chk("rand_idle_stall", 32'(stall), 0);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
